// File: rtl/hex_seg_dimmer_if.sv
// Avalon-MM slave bus carrying the dimmer's four configuration words.
interface hex_seg_dimmer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/hex_seg_dimmer.sv
// PWM brightness and blink gate between a HEX PIO segment port and the pins.
// Comes out of reset as a transparent full-brightness pass-through.
module hex_seg_dimmer #(
    parameter int unsigned PRESCALE = 195
) (
    input  logic             clk,
    input  logic             reset,
    hex_seg_dimmer_if.slave  bus,
    input  logic [6:0]       seg_in,
    output logic [6:0]       seg_out
);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt;
    logic [7:0]  pwm_cnt;
    logic [15:0] frame_cnt;
    logic        blink_phase;
    logic        enable;
    logic        blink_en;
    logic [7:0]  duty_req;
    logic [7:0]  duty_act;
    logic [15:0] blink_div;

    logic wr, wr_ctrl, wr_duty, wr_div;
    logic tick, frame_bnd, pwm_on, gate;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr && (bus.address == 2'd0);
    assign wr_duty   = wr && (bus.address == 2'd1);
    assign wr_div    = wr && (bus.address == 2'd2);

    assign tick      = (pre_cnt == PRE_MAX);
    assign frame_bnd = tick && (pwm_cnt == 8'hFF);
    assign pwm_on    = (duty_act == 8'hFF) || (pwm_cnt < duty_act);
    assign gate      = enable & pwm_on & (blink_phase | ~blink_en);

    // Prescaler, PWM step counter and frame-aligned duty shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            duty_act <= 8'hFF;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            // duty_req is read before this edge's write lands, so a write
            // on the boundary cycle waits one more frame.
            if (frame_bnd)
                duty_act <= duty_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= 1'b1;
            blink_en  <= 1'b0;
            duty_req  <= 8'hFF;
            blink_div <= 16'd250;
        end else begin
            if (wr_ctrl) begin
                enable   <= bus.writedata[0];
                blink_en <= bus.writedata[1];
            end
            if (wr_duty)
                duty_req <= bus.writedata[7:0];
            if (wr_div)
                blink_div <= bus.writedata[15:0];
        end
    end

    // Blink counter: a BLINK_DIV write restarts the half-period visible
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_div || (blink_div == 16'd0)) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_bnd) begin
            if (frame_cnt == blink_div - 16'd1) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            seg_out <= 7'h7F;
        else
            seg_out <= gate ? seg_in : 7'h7F;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata = {30'd0, blink_en, enable};
            2'd1: bus.readdata = {24'd0, duty_req};
            2'd2: bus.readdata = {16'd0, blink_div};
            2'd3: bus.readdata = {16'd0, pwm_cnt, 7'd0, blink_phase};
            default: bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_hex_seg_dimmer.sv
// Directed bench for hex_seg_dimmer with PRESCALE=1 (one PWM step per clock).
module tb_hex_seg_dimmer;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic [6:0] seg_out;

    int unsigned cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    hex_seg_dimmer_if bus ();

    hex_seg_dimmer #(.PRESCALE(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .seg_in  (seg_in),
        .seg_out (seg_out)
    );

    always #5 clk = ~clk;

    // With PRESCALE=1 the DUT's pwm_cnt equals cyc mod 256 between edges
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    // Always advances at least one cycle, so a phase already reached means a full frame
    task automatic wait_phase(input int ph);
        int n = 0;
        step();
        while (((cyc % 256) != ph) && (n < 1024)) begin
            step();
            n++;
        end
        check("wait_phase", 32'(cyc % 256), 32'(ph));
    endtask

    task automatic count_vis(input int n, output int vis);
        vis = 0;
        repeat (n) begin
            step();
            if (seg_out === seg_in) vis++;
        end
    endtask

    logic [31:0] rd;
    int          vis;

    initial begin
        reset          = 1'b1;
        seg_in         = 7'h00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Pass-through after reset
        step();
        step();
        check("rst_seg_out", 32'(seg_out), 32'h7F);
        bus_read(2'd0, rd); check("rst_ctrl", rd, 32'h1);
        bus_read(2'd1, rd); check("rst_duty", rd, 32'hFF);
        bus_read(2'd2, rd); check("rst_div", rd, 32'd250);
        bus_read(2'd3, rd); check("rst_status", rd, 32'h1);
        reset  = 1'b0;
        seg_in = 7'h40;
        step();
        check("pass_first", 32'(seg_out), 32'h40);
        count_vis(768, vis);
        check("pass_3frames", 32'(vis), 32'd768);

        // Dimming to 64/256
        seg_in = 7'h12;
        wait_phase(10);
        bus_write(2'd1, 32'd64);
        wait_phase(0);
        count_vis(64, vis);
        check("dim64_on", 32'(vis), 32'd64);
        count_vis(192, vis);
        check("dim64_off", 32'(vis), 32'd0);

        wait_phase(10);
        bus_write(2'd1, 32'd0);
        wait_phase(0);
        count_vis(256, vis);
        check("dim0_dark", 32'(vis), 32'd0);

        // Mid-frame duty change deferred to the next frame
        wait_phase(10);
        bus_write(2'd1, 32'd64);
        wait_phase(0);
        wait_phase(100);
        bus_write(2'd1, 32'd200);
        count_vis(155, vis);
        check("glitch_old_duty", 32'(vis), 32'd0);
        count_vis(256, vis);
        check("glitch_new_duty", 32'(vis), 32'd200);

        // Write landing on the boundary edge waits a whole extra frame
        wait_phase(255);
        bus_write(2'd1, 32'd30);
        count_vis(256, vis);
        check("bnd_deferred", 32'(vis), 32'd200);
        count_vis(256, vis);
        check("bnd_applied", 32'(vis), 32'd30);

        // Blink with BLINK_DIV=2
        seg_in = 7'h21;
        bus_write(2'd1, 32'd255);
        wait_phase(0);
        wait_phase(200);
        bus_write(2'd0, 32'h3);
        wait_phase(255);
        bus_write(2'd2, 32'd2);
        count_vis(512, vis);
        check("blink_vis1", 32'(vis), 32'd512);
        count_vis(512, vis);
        check("blink_dark", 32'(vis), 32'd0);
        count_vis(512, vis);
        check("blink_vis2", 32'(vis), 32'd512);
        count_vis(100, vis);
        check("blink_dark2", 32'(vis), 32'd0);
        bus_write(2'd2, 32'd0);
        count_vis(1024, vis);
        check("blink_div0", 32'(vis), 32'd1024);

        // Register access
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd0, rd); check("reg_ctrl", rd, 32'h3);
        bus_read(2'd1, rd); check("reg_duty", rd, 32'hFF);
        bus_read(2'd2, rd); check("reg_div", rd, 32'hFFFF);
        bus_write(2'd3, 32'h0);
        bus_read(2'd0, rd); check("st_wr_ctrl", rd, 32'h3);
        bus_read(2'd1, rd); check("st_wr_duty", rd, 32'hFF);
        bus_read(2'd2, rd); check("st_wr_div", rd, 32'hFFFF);
        step();
        bus_read(2'd3, rd); check("status_a", rd, {16'h0, 8'(cyc % 256), 8'h01});
        repeat (37) step();
        bus_read(2'd3, rd); check("status_b", rd, {16'h0, 8'(cyc % 256), 8'h01});

        // Reset during a dark blink phase
        bus_write(2'd1, 32'd10);
        wait_phase(255);
        bus_write(2'd2, 32'd1);
        wait_phase(0);
        wait_phase(50);
        seg_in = 7'h5A;
        count_vis(5, vis);
        check("pre_rst_dark", 32'(vis), 32'd0);
        reset = 1'b1;
        step();
        check("midrst_seg", 32'(seg_out), 32'h7F);
        bus_read(2'd0, rd); check("midrst_ctrl", rd, 32'h1);
        bus_read(2'd1, rd); check("midrst_duty", rd, 32'hFF);
        bus_read(2'd3, rd); check("midrst_status", rd, 32'h1);
        reset = 1'b0;
        step();
        check("post_rst_pass", 32'(seg_out), 32'h5A);
        count_vis(300, vis);
        check("post_rst_steady", 32'(vis), 32'd300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
